ifid_pipe_stage: RTL and testbench

//  Parametrised IF/ID pipeline stage with valid/ready handshake, synchronous flush and NOP injection.

---
 rtl/ifid_pkg.sv | 15 +
 rtl/ifid_skid_reg.sv | 39 +++
 rtl/ifid_pipe_stage.sv | 110 +++++++++++
 tb/tb_ifid_pipe_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ifid_pkg.sv
// ifid_pkg: shared defaults and types for the IF/ID pipeline stage.
package ifid_pkg;

  localparam int          IFID_PC_W    = 32;
  localparam int          IFID_INSTR_W = 32;
  localparam int          IFID_CNT_W   = 16;
  localparam logic [31:0] IFID_NOP     = 32'h0000_0000;

  // One fetched word as carried through the stage (default widths).
  typedef struct packed {
    logic [IFID_PC_W-1:0]    pc;
    logic [IFID_INSTR_W-1:0] instr;
  } ifid_word_t;

endpackage

// File: rtl/ifid_skid_reg.sv
// ifid_skid_reg: one-entry holding register with valid bit.
// Flush has priority over load; drain empties the entry when the main
// register takes the held word.
module ifid_skid_reg #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         load,
  input  logic         drain,
  input  logic [W-1:0] data_in,
  output logic         valid,
  output logic [W-1:0] data_out
);

  // Entry occupancy: flush wins, then capture, then release to main.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

  // Payload only needs to be captured; it is ignored while valid=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (load && !flush) begin
      data_out <= data_in;
    end
  end

endmodule

// File: rtl/ifid_pipe_stage.sv
// ifid_pipe_stage: IF/ID pipeline stage with valid/ready handshake,
// synchronous flush with NOP injection and a saturating stall counter.
// Optional build macro IFID_SKID_EN: adds a one-entry skid buffer so that
// inReady is a flop output with no combinational path from outReady.
module ifid_pipe_stage
  import ifid_pkg::*;
#(
  parameter int                 PC_W      = IFID_PC_W,
  parameter int                 INSTR_W   = IFID_INSTR_W,
  parameter logic [INSTR_W-1:0] NOP_VALUE = INSTR_W'(IFID_NOP),
  parameter int                 CNT_W     = IFID_CNT_W
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic               flush,
  input  logic               inValid,
  output logic               inReady,
  input  logic [PC_W-1:0]    nextPcInput,
  input  logic [INSTR_W-1:0] instructionInput,
  output logic               outValid,
  input  logic               outReady,
  output logic [PC_W-1:0]    nextPcOutput,
  output logic [INSTR_W-1:0] instructionOutput,
  output logic [CNT_W-1:0]   stallCount
);

  logic               can_load;
  logic               accept_in;
  logic               load_valid;
  logic [PC_W-1:0]    load_pc;
  logic [INSTR_W-1:0] load_instr;

  // Main register may take a new word when empty or when its word leaves.
  always_comb begin
    can_load  = !outValid || outReady;
    accept_in = inValid && inReady;
  end

`ifdef IFID_SKID_EN
  logic                      skid_valid;
  logic [PC_W+INSTR_W-1:0]   skid_data;

  // A word accepted while main is stalled parks in the skid; the skid is
  // only full while main is full, so it always drains ahead of new input.
  ifid_skid_reg #(
    .W (PC_W + INSTR_W)
  ) u_skid (
    .clk      (clock),
    .rst_n    (resetN),
    .flush    (flush),
    .load     (accept_in && !can_load),
    .drain    (can_load),
    .data_in  ({nextPcInput, instructionInput}),
    .valid    (skid_valid),
    .data_out (skid_data)
  );

  assign inReady = !skid_valid;

  // Main register source: skid contents first, otherwise the input port.
  always_comb begin
    load_valid = skid_valid || accept_in;
    load_pc    = nextPcInput;
    load_instr = instructionInput;
    if (skid_valid) begin
      load_pc    = skid_data[PC_W+INSTR_W-1:INSTR_W];
      load_instr = skid_data[INSTR_W-1:0];
    end
  end
`else
  assign inReady = can_load;

  // Main register source: the input port only.
  always_comb begin
    load_valid = accept_in;
    load_pc    = nextPcInput;
    load_instr = instructionInput;
  end
`endif

  // Main register: flush squashes, otherwise load/hold per handshake.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      outValid          <= 1'b0;
      nextPcOutput      <= '0;
      instructionOutput <= NOP_VALUE;
    end else if (flush) begin
      outValid          <= 1'b0;
      instructionOutput <= NOP_VALUE;
    end else if (can_load) begin
      outValid <= load_valid;
      if (load_valid) begin
        nextPcOutput      <= load_pc;
        instructionOutput <= load_instr;
      end else begin
        instructionOutput <= NOP_VALUE;
      end
    end
  end

  // Saturating count of cycles where decode holds off a valid word.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      stallCount <= '0;
    end else if (outValid && !outReady && (stallCount != '1)) begin
      stallCount <= stallCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ifid_pipe_stage.sv
// tb_ifid_pipe_stage: directed stimulus with a scoreboard queue of expected
// words; a negedge monitor pops and compares on every output transfer.
module tb_ifid_pipe_stage;
  import ifid_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        sat_rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        inValid = 1'b0;
  logic        outReady = 1'b0;
  logic [31:0] nextPcInput = '0;
  logic [31:0] instructionInput = '0;

  logic        inReady, outValid;
  logic [31:0] nextPcOutput, instructionOutput;
  logic [15:0] stallCount;

  logic        s_inReady, s_outValid;
  logic [31:0] s_nextPcOutput, s_instructionOutput;
  logic [1:0]  s_stallCount;

  int checks = 0;
  int errors = 0;
  ifid_word_t exp_q[$];
  ifid_word_t w;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_pc, prev_ins;

  always #5 clock = ~clock;

  ifid_pipe_stage #(
    .PC_W (32), .INSTR_W (32), .NOP_VALUE (32'h0000_0000), .CNT_W (16)
  ) dut (
    .clock (clock), .resetN (resetN), .flush (flush),
    .inValid (inValid), .inReady (inReady),
    .nextPcInput (nextPcInput), .instructionInput (instructionInput),
    .outValid (outValid), .outReady (outReady),
    .nextPcOutput (nextPcOutput), .instructionOutput (instructionOutput),
    .stallCount (stallCount)
  );

  ifid_pipe_stage #(
    .PC_W (32), .INSTR_W (32), .NOP_VALUE (32'h0000_0000), .CNT_W (2)
  ) dut_sat (
    .clock (clock), .resetN (resetN & sat_rst_n), .flush (flush),
    .inValid (inValid), .inReady (s_inReady),
    .nextPcInput (nextPcInput), .instructionInput (instructionInput),
    .outValid (s_outValid), .outReady (outReady),
    .nextPcOutput (s_nextPcOutput), .instructionOutput (s_instructionOutput),
    .stallCount (s_stallCount)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // One cycle: drive at posedge+1, record the expected transfer, step.
  task automatic cyc(input logic v, input logic [31:0] a_pc, input logic [31:0] a_ins,
                     input logic r, input logic f);
    inValid = v; nextPcInput = a_pc; instructionInput = a_ins;
    outReady = r; flush = f;
    #3;
    if (f) exp_q.delete();
    else if (v && inReady) exp_q.push_back('{pc: a_pc, instr: a_ins});
    @(posedge clock);
    #1;
  endtask

  // Monitor: compare presented words on transfer-out, NOP when idle,
  // and stability of outputs across a stall.
  always @(negedge clock) begin
    if (resetN) begin
      if (!outValid) chk("nop_when_idle", instructionOutput, NOP);
      if (sat_rst_n && !s_outValid) chk("sat_nop_when_idle", s_instructionOutput, NOP);
      if (prev_stall && outValid) begin
        chk("frozen_pc", nextPcOutput, prev_pc);
        chk("frozen_instr", instructionOutput, prev_ins);
      end
      if (outValid && outReady) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got pc %0h instr %0h required none",
                   nextPcOutput, instructionOutput);
        end else begin
          w = exp_q.pop_front();
          chk("out_pc", nextPcOutput, w.pc);
          chk("out_instr", instructionOutput, w.instr);
          chk("sat_out_valid", s_outValid, 1);
          chk("sat_out_pc", s_nextPcOutput, w.pc);
          chk("sat_out_instr", s_instructionOutput, w.instr);
        end
      end
      prev_stall = outValid && !outReady && !flush;
      prev_pc    = nextPcOutput;
      prev_ins   = instructionOutput;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    // Reset state
    @(posedge clock); #1;
    chk("rst_out_valid", outValid, 0);
    chk("rst_pc", nextPcOutput, 0);
    chk("rst_instr", instructionOutput, NOP);
    chk("rst_stall", stallCount, 0);
    chk("rst_in_ready", inReady, 1);
    #2 resetN = 1'b1;
    @(posedge clock); #1;

    // 1: single word, one-cycle latency
    cyc(1'b1, 32'h4, 32'h2002_0005, 1'b1, 1'b0);
    chk("t1_out_valid", outValid, 1);
    chk("t1_pc", nextPcOutput, 32'h4);
    chk("t1_instr", instructionOutput, 32'h2002_0005);

    // 2: eight back-to-back words, no gaps
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 32'h8 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b1, 1'b0);
      chk("t2_out_valid", outValid, 1);
      chk("t2_pc", nextPcOutput, 32'h8 + 32'(4 * i));
    end
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t2_drained", outValid, 0);
    chk("t2_stall", stallCount, 0);

    // 3: three-cycle stall with one extra word offered
    cyc(1'b1, 32'h100, 32'h1111, 1'b1, 1'b0);
    cyc(1'b1, 32'h104, 32'h2222, 1'b0, 1'b0);
    chk("t3_in_ready_after_stall1", inReady, 0);
    chk("t3_stall1", stallCount, 1);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0);
    chk("t3_stall3", stallCount, 3);
    chk("t3_held_instr", instructionOutput, 32'h1111);
    chk("t3_held_pc", nextPcOutput, 32'h100);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
`ifdef IFID_SKID_EN
    chk("t3_skid_out_valid", outValid, 1);
    chk("t3_skid_instr", instructionOutput, 32'h2222);
    chk("t3_skid_in_ready", inReady, 1);
`else
    chk("t3_out_valid", outValid, 0);
`endif
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t3_empty", outValid, 0);
    chk("t3_stall_kept", stallCount, 3);

    // 4: flush with a simultaneous input word
    cyc(1'b1, 32'h200, 32'h3333, 1'b0, 1'b0);
    chk("t4_loaded", outValid, 1);
    cyc(1'b1, 32'h204, 32'h4444, 1'b0, 1'b1);
    chk("t4_out_valid", outValid, 0);
    chk("t4_instr_nop", instructionOutput, NOP);
    chk("t4_pc_held", nextPcOutput, 32'h200);
    chk("t4_stall", stallCount, 4);
    chk("t4_in_ready", inReady, 1);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t4_still_empty", outValid, 0);

    // 5: 2-bit counter saturates at 3
    sat_rst_n = 1'b0;
    #1;
    chk("t5_sat_reset", s_stallCount, 0);
    sat_rst_n = 1'b1;
    @(posedge clock); #1;
    cyc(1'b1, 32'h300, 32'h5555, 1'b1, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b0, '0, '0, 1'b0, 1'b0);
      chk("t5_sat_count", s_stallCount, (k < 3) ? k : 3);
      chk("t5_wide_count", stallCount, 4 + k);
    end

    // 6: asynchronous reset mid-stall
    #2 resetN = 1'b0;
    #1;
    chk("t6_out_valid", outValid, 0);
    chk("t6_stall", stallCount, 0);
    chk("t6_in_ready", inReady, 1);
    chk("t6_instr", instructionOutput, NOP);
    chk("t6_sat_out_valid", s_outValid, 0);
    exp_q.delete();
    #2 resetN = 1'b1;
    @(posedge clock); #1;
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t6_no_stale_word", outValid, 0);
    cyc(1'b1, 32'h400, 32'h6666, 1'b1, 1'b0);
    chk("t6_new_word", instructionOutput, 32'h6666);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);

    for (int n = 0; n < 10 && exp_q.size() != 0; n++) cyc(1'b0, '0, '0, 1'b1, 1'b0);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
